// File: rtl/hysteresis_delayer_pkg.sv
// Shared state encoding and delay helper for the hysteresis glitch filter.
package hysteresis_delayer_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } state_t;

  // A programmed delay of 0 is treated as 1 so there is never a combinational bypass.
  function automatic logic [31:0] eff_delay(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/hysteresis_delayer_ch.sv
// One filter channel: optional input synchroniser, LOW/RISE/HIGH/FALL FSM and qualification counter.
module hysteresis_delayer_ch
  import hysteresis_delayer_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic [BIT_WIDTH-1:0] rise_delay,
  input  logic [BIT_WIDTH-1:0] fall_delay,
  output logic                 out,
  output logic                 rise_pulse,
  output logic                 fall_pulse
);

  localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1);

  logic in_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign in_s = in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync <= '0;
        end else begin
          sync[0] <= in;
          for (int j = 1; j < SYNC_STAGES; j++) sync[j] <= sync[j-1];
        end
      end
      assign in_s = sync[SYNC_STAGES-1];
    end
  endgenerate

  logic [BIT_WIDTH-1:0] dr, df;
  assign dr = BIT_WIDTH'(eff_delay(32'(rise_delay)));
  assign df = BIT_WIDTH'(eff_delay(32'(fall_delay)));

  state_t               state, state_nxt;
  logic [BIT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 rise_nxt, fall_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOW;
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // Delays are latched into cnt only on entry to RISE/FALL, so later changes never disturb a running count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        if (in_s) begin
          if (dr == ONE) begin
            state_nxt = HIGH;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = RISE;
            cnt_nxt   = dr - ONE;
          end
        end
      end
      RISE: begin
        if (!in_s) begin
          state_nxt = LOW;
        end else if (cnt == ONE) begin
          state_nxt = HIGH;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      HIGH: begin
        if (!in_s) begin
          if (df == ONE) begin
            state_nxt = LOW;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = FALL;
            cnt_nxt   = df - ONE;
          end
        end
      end
      FALL: begin
        if (in_s) begin
          state_nxt = HIGH;
        end else if (cnt == ONE) begin
          state_nxt = LOW;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: state_nxt = LOW;
    endcase
  end

  assign out = (state == HIGH) || (state == FALL);

endmodule

// File: rtl/hysteresis_delayer.sv
// Multi-channel hysteresis glitch filter; fans the shared delays out to independent channels.
module hysteresis_delayer
  import hysteresis_delayer_pkg::*;
#(
  parameter int N_CHANNELS  = 4,
  parameter int BIT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] in,
  input  logic [BIT_WIDTH-1:0]  rise_delay,
  input  logic [BIT_WIDTH-1:0]  fall_delay,
  output logic [N_CHANNELS-1:0] out,
  output logic [N_CHANNELS-1:0] rise_pulse,
  output logic [N_CHANNELS-1:0] fall_pulse
);

  generate
    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
      hysteresis_delayer_ch #(
        .BIT_WIDTH   (BIT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .in         (in[i]),
        .rise_delay (rise_delay),
        .fall_delay (fall_delay),
        .out        (out[i]),
        .rise_pulse (rise_pulse[i]),
        .fall_pulse (fall_pulse[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_hysteresis_delayer.sv
// Directed bench: one filter with a 2-stage synchroniser and one without, sharing stimulus.
module tb_hysteresis_delayer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_bits;
  logic [15:0] rise_d, fall_d;
  logic [3:0]  out2, rp2, fp2;
  logic [3:0]  out0, rp0, fp0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hysteresis_delayer #(.N_CHANNELS(4), .BIT_WIDTH(16), .SYNC_STAGES(2)) dut_s2 (
    .clk(clk), .reset(reset), .in(in_bits), .rise_delay(rise_d), .fall_delay(fall_d),
    .out(out2), .rise_pulse(rp2), .fall_pulse(fp2)
  );

  hysteresis_delayer #(.N_CHANNELS(4), .BIT_WIDTH(16), .SYNC_STAGES(0)) dut_s0 (
    .clk(clk), .reset(reset), .in(in_bits), .rise_delay(rise_d), .fall_delay(fall_d),
    .out(out0), .rise_pulse(rp0), .fall_pulse(fp0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_bits = 4'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    in_bits = 4'hF;
    rise_d  = 16'd5;
    fall_d  = 16'd5;
    tick();
    tick();
    tick();
    checks++;
    if (out2 !== 4'h0 || rp2 !== 4'h0 || fp2 !== 4'h0) begin
      errors++;
      $display("FAIL reset_hold: out=%h rp=%h fp=%h expected 0/0/0", out2, rp2, fp2);
    end
    checks++;
    if (out0 !== 4'h0) begin
      errors++;
      $display("FAIL reset_hold_s0: out=%h expected 0", out0);
    end
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) tick();
    checks++;
    if (out2 !== 4'h0 || rp2 !== 4'h0) begin
      errors++;
      $display("FAIL reset_rise_early: out=%h rp=%h expected 0/0 after edge 6", out2, rp2);
    end
    tick();
    checks++;
    if (out2 !== 4'hF || rp2 !== 4'hF || fp2 !== 4'h0) begin
      errors++;
      $display("FAIL reset_rise_edge7: out=%h rp=%h fp=%h expected F/F/0", out2, rp2, fp2);
    end
    tick();
    checks++;
    if (out2 !== 4'hF || rp2 !== 4'h0) begin
      errors++;
      $display("FAIL reset_rise_pulse_width: out=%h rp=%h expected F/0", out2, rp2);
    end
  endtask

  task automatic test_rise_glitch();
    logic seen_out, seen_p;
    do_reset();
    rise_d   = 16'd8;
    fall_d   = 16'd1;
    seen_out = 1'b0;
    seen_p   = 1'b0;
    in_bits  = 4'h1;
    for (int e = 0; e < 7; e++) begin
      tick();
      seen_out |= out0[0];
      seen_p   |= rp0[0];
    end
    in_bits = 4'h0;
    tick();
    seen_out |= out0[0];
    seen_p   |= rp0[0];
    checks++;
    if (seen_out !== 1'b0 || seen_p !== 1'b0) begin
      errors++;
      $display("FAIL rise_glitch_7: out_seen=%b pulse_seen=%b expected 0/0", seen_out, seen_p);
    end
    in_bits = 4'h1;
    for (int e = 0; e < 7; e++) tick();
    checks++;
    if (out0[0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_8_early: out0=%b expected 0 after 7th high", out0[0]);
    end
    tick();
    checks++;
    if (out0[0] !== 1'b1 || rp0[0] !== 1'b1) begin
      errors++;
      $display("FAIL rise_8: out0=%b rp0=%b expected 1/1 after 8th high", out0[0], rp0[0]);
    end
  endtask

  task automatic test_asym();
    logic low_seen;
    int   fp_count;
    do_reset();
    rise_d   = 16'd3;
    fall_d   = 16'd10;
    in_bits  = 4'h2;
    for (int e = 0; e < 20; e++) tick();
    checks++;
    if (out0[1] !== 1'b1) begin
      errors++;
      $display("FAIL asym_high: out1=%b expected 1", out0[1]);
    end
    low_seen = 1'b0;
    fp_count = 0;
    in_bits  = 4'h0;
    for (int e = 0; e < 9; e++) begin
      tick();
      low_seen |= ~out0[1];
      fp_count += int'(fp0[1]);
    end
    in_bits = 4'h2;
    tick();
    low_seen |= ~out0[1];
    fp_count += int'(fp0[1]);
    checks++;
    if (low_seen !== 1'b0 || fp_count != 0) begin
      errors++;
      $display("FAIL asym_gap9: low_seen=%b fall_pulses=%0d expected 0/0", low_seen, fp_count);
    end
    in_bits = 4'h0;
    for (int e = 0; e < 9; e++) tick();
    checks++;
    if (out0[1] !== 1'b1 || fp0[1] !== 1'b0) begin
      errors++;
      $display("FAIL asym_fall_early: out1=%b fp1=%b expected 1/0 after 9th low", out0[1], fp0[1]);
    end
    tick();
    fp_count += int'(fp0[1]);
    checks++;
    if (out0[1] !== 1'b0 || fp0[1] !== 1'b1) begin
      errors++;
      $display("FAIL asym_fall10: out1=%b fp1=%b expected 0/1 after 10th low", out0[1], fp0[1]);
    end
    tick();
    fp_count += int'(fp0[1]);
    checks++;
    if (fp_count != 1) begin
      errors++;
      $display("FAIL asym_fall_count: fall_pulses=%0d expected 1", fp_count);
    end
  endtask

  task automatic test_zero_delay();
    logic [3:0] pat [9];
    logic [3:0] prev;
    pat = '{4'h1, 4'h0, 4'h5, 4'hA, 4'hF, 4'hF, 4'h3, 4'h8, 4'h0};
    do_reset();
    rise_d = 16'd0;
    fall_d = 16'd0;
    prev   = 4'h0;
    for (int i = 0; i < 9; i++) begin
      in_bits = pat[i];
      tick();
      checks++;
      if (out0 !== pat[i] || rp0 !== (pat[i] & ~prev) || fp0 !== (~pat[i] & prev)) begin
        errors++;
        $display("FAIL zero_delay[%0d]: out=%h rp=%h fp=%h expected %h/%h/%h", i, out0, rp0, fp0,
                 pat[i], pat[i] & ~prev, ~pat[i] & prev);
      end
      prev = pat[i];
    end
  endtask

  task automatic test_mid_change();
    logic seen;
    do_reset();
    rise_d  = 16'd100;
    fall_d  = 16'd1;
    in_bits = 4'h1;
    seen    = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      seen |= out0[0];
    end
    rise_d = 16'd2;
    for (int e = 11; e <= 99; e++) begin
      tick();
      seen |= out0[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_change_early: out0 rose before sample 100");
    end
    tick();
    checks++;
    if (out0[0] !== 1'b1 || rp0[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_change_100: out0=%b rp0=%b expected 1/1", out0[0], rp0[0]);
    end
  endtask

  task automatic test_indep_async();
    int   rp_ch0, rp_ch3;
    logic bad;
    do_reset();
    rise_d = 16'd2;
    fall_d = 16'd2;
    rp_ch0 = 0;
    rp_ch3 = 0;
    bad    = 1'b0;
    for (int e = 0; e < 12; e++) begin
      in_bits = {1'b1, 2'b00, ((e % 6) < 3)};
      tick();
      rp_ch0 += int'(rp0[0]);
      rp_ch3 += int'(rp0[3]);
      bad |= out0[1] | out0[2] | rp0[1] | rp0[2];
      if (e >= 1) bad |= ~out0[3];
    end
    checks++;
    if (rp_ch0 != 2 || rp_ch3 != 1 || bad !== 1'b0) begin
      errors++;
      $display("FAIL indep: rp_ch0=%0d rp_ch3=%0d crosstalk=%b expected 2/1/0", rp_ch0, rp_ch3, bad);
    end
    fall_d  = 16'd10;
    in_bits = 4'h0;
    tick();
    tick();
    tick();
    checks++;
    if (out0[3] !== 1'b1 || out2[3] !== 1'b1) begin
      errors++;
      $display("FAIL fall_hold: out0[3]=%b out2[3]=%b expected 1/1", out0[3], out2[3]);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out0 !== 4'h0 || fp0 !== 4'h0 || out2 !== 4'h0 || fp2 !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: out0=%h fp0=%h out2=%h fp2=%h expected all 0", out0, fp0, out2, fp2);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    in_bits = 4'h0;
    rise_d  = 16'd1;
    fall_d  = 16'd1;
    test_reset();
    test_rise_glitch();
    test_asym();
    test_zero_delay();
    test_mid_change();
    test_indep_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
